// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC SPI interface: state encoding,
// frame geometry and the channel-address word sent to the ADC.
package a2d_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_W       = 3;
    localparam int RES_W      = 12;

    // Divider preload sits this many counts below SCLK_DIV so the first
    // falling SCLK event follows a short front porch after SS_n drops.
    localparam int DIV_FRONT  = 9;

    typedef enum logic [2:0] {
        IDLE,
        FRM1,
        GAP,
        FRM2,
        DONE
    } state_t;

    function automatic int div_preload(input int sclk_div);
        return sclk_div - DIV_FRONT;
    endfunction

    // ADC control word: two don't-care bits, 3-bit address, then zeros.
    function automatic logic [FRAME_BITS-1:0] chan_word(input logic [CH_W-1:0] ch);
        return {2'b00, ch, {(FRAME_BITS - 2 - CH_W){1'b0}}};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_frame16.sv
// Single 16-bit SPI frame engine (mode 3): drives SS_n/SCLK/MOSI, samples
// MISO on SCLK rise and returns the shifted-in word with a done pulse.
module spi_frame16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32,
    parameter int RX_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    input  logic                  MISO,
    output logic                  done,
    output logic [RX_W-1:0]       rx_word,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_ONES = '1;
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_ONES >> 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_ONES - 1'b1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(div_preload(SCLK_DIV));
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic                  busy_reg,  busy_next;
    logic [DIV_W-1:0]      div_reg,   div_next;
    logic [CNT_W-1:0]      cnt_reg,   cnt_next;
    logic [FRAME_BITS-1:0] shift_reg, shift_next;
    logic                  smp_reg,   smp_next;
    logic                  mosi_reg,  mosi_next;
    logic                  done_reg,  done_next;
    logic                  ss_n_reg,  ss_n_next;
    logic                  sclk_reg,  sclk_next;

    always_comb begin
        busy_next  = busy_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        smp_next   = smp_reg;
        mosi_next  = mosi_reg;
        done_next  = 1'b0;

        if (!busy_reg) begin
            mosi_next = 1'b0;
            if (start) begin
                busy_next  = 1'b1;
                div_next   = DIV_LOAD;
                cnt_next   = '0;
                shift_next = tx_word;
            end
        end else begin
            div_next = div_reg + 1'b1;
            if (cnt_reg == CNT_FULL && div_reg == DIV_LAST) begin
                // Last bit: shift it in and close the frame with SCLK parked high.
                shift_next = {shift_reg[FRAME_BITS-2:0], smp_reg};
                busy_next  = 1'b0;
                done_next  = 1'b1;
                mosi_next  = 1'b0;
            end else if (div_reg == DIV_ONES) begin
                if (cnt_reg != '0) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], smp_reg};
                end
                mosi_next = shift_next[FRAME_BITS-1];
            end else if (div_reg == DIV_RISE) begin
                smp_next = MISO;
                cnt_next = cnt_reg + 1'b1;
            end
        end

        ss_n_next = ~busy_next;
        sclk_next = ~busy_next | div_next[DIV_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            shift_reg <= '0;
            smp_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ss_n_reg  <= 1'b1;
            sclk_reg  <= 1'b1;
        end else begin
            busy_reg  <= busy_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            smp_reg   <= smp_next;
            mosi_reg  <= mosi_next;
            done_reg  <= done_next;
            ss_n_reg  <= ss_n_next;
            sclk_reg  <= sclk_next;
        end
    end

    assign done    = done_reg;
    assign rx_word = shift_reg[RX_W-1:0];
    assign SS_n    = ss_n_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = mosi_reg;

endmodule

// File: rtl/a2d_intf.sv
// A2D request handshake: turns each strt_cnv into an address frame, a
// chip-select gap and a data frame, then presents the 12-bit result.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CLKS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_cnv,
    input  logic [CH_W-1:0]  chnnl,
    input  logic             MISO,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] A2D_res,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI
);

    localparam int GAP_W = $clog2(GAP_CLKS);
    // Done-pulse register and the launch cycle each eat one gap clock.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLKS - 3);

    state_t           state_reg,  state_next;
    logic [CH_W-1:0]  chnnl_reg,  chnnl_next;
    logic [GAP_W-1:0] gap_reg,    gap_next;
    logic             launch_reg, launch_next;
    logic             cmplt_reg,  cmplt_next;
    logic [RES_W-1:0] res_reg,    res_next;

    logic             frame_done;
    logic [RES_W-1:0] frame_rx;

    always_comb begin
        state_next  = state_reg;
        chnnl_next  = chnnl_reg;
        gap_next    = gap_reg;
        launch_next = 1'b0;
        cmplt_next  = cmplt_reg;
        res_next    = res_reg;

        unique case (state_reg)
            IDLE: begin
                if (strt_cnv) begin
                    chnnl_next  = chnnl;
                    cmplt_next  = 1'b0;
                    launch_next = 1'b1;
                    state_next  = FRM1;
                end
            end
            FRM1: begin
                if (frame_done) begin
                    gap_next   = GAP_LOAD;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_reg == '0) begin
                    launch_next = 1'b1;
                    state_next  = FRM2;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            FRM2: begin
                if (frame_done) begin
                    res_next   = frame_rx;
                    cmplt_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            chnnl_reg  <= '0;
            gap_reg    <= '0;
            launch_reg <= 1'b0;
            cmplt_reg  <= 1'b0;
            res_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            chnnl_reg  <= chnnl_next;
            gap_reg    <= gap_next;
            launch_reg <= launch_next;
            cmplt_reg  <= cmplt_next;
            res_reg    <= res_next;
        end
    end

    spi_frame16 #(
        .SCLK_DIV (SCLK_DIV),
        .RX_W     (RES_W)
    ) u_frame (
        .clk     (clk),
        .rst     (rst),
        .start   (launch_reg),
        .tx_word (chan_word(chnnl_reg)),
        .MISO    (MISO),
        .done    (frame_done),
        .rx_word (frame_rx),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    assign cnv_cmplt = cmplt_reg;
    assign A2D_res   = res_reg;

endmodule

// File: tb/tb_a2d_intf.sv
// Randomized scoreboard bench for a2d_intf with a behavioural ADC that
// decodes the address frame and returns the addressed channel's sample.
module tb_a2d_intf;

    localparam int LAT       = 1074;
    localparam int FRAME_LOW = 520;
    localparam int GAP_HIGH  = 32;
    localparam int SCLK_PER  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        MISO = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    always #5 clk = ~clk;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (MISO),
        .cnv_cmplt (cnv_cmplt),
        .A2D_res   (A2D_res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: address from the previous full frame, data MSB first on SCLK fall.
    logic [11:0] adc_mem [8];
    logic [3:0]  upper_nib = 4'h0;
    logic [15:0] adc_word  = 16'h0;
    logic [15:0] din_bits  = 16'h0;
    logic [2:0]  adc_addr  = 3'd0;
    int          adc_idx   = 0;
    int          din_cnt   = 0;

    always @(negedge SS_n) begin
        adc_word = {upper_nib, adc_mem[adc_addr]};
        adc_idx  = 0;
        din_cnt  = 0;
    end
    always @(negedge SCLK) begin
        if (!SS_n && adc_idx < 16) begin
            MISO = adc_word[15 - adc_idx];
            adc_idx++;
        end
    end
    always @(posedge SCLK) begin
        if (!SS_n) begin
            din_bits = {din_bits[14:0], MOSI};
            din_cnt++;
        end
    end
    always @(posedge SS_n) begin
        if (din_cnt == 16) adc_addr = din_bits[13:11];
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        int          t0;
    } exp_t;
    exp_t sb[$];

    // Monitor: frame timing, MOSI word, and result pops on cnv_cmplt rise.
    logic        prev_ss_n  = 1'b1;
    logic        prev_sclk  = 1'b1;
    logic        prev_cmplt = 1'b0;
    int          low_start  = 0;
    int          high_start = 0;
    int          last_rise  = 0;
    int          rise_cnt   = 0;
    int          frames     = 0;
    int          idle_bad   = 0;
    int          per_bad    = 0;
    int          done_cnt   = 0;
    logic [15:0] mosi_word  = 16'h0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            frames   = 0;
            rise_cnt = 0;
            idle_bad = 0;
        end else begin
            if (prev_ss_n && !SS_n) begin
                frames++;
                rise_cnt  = 0;
                per_bad   = 0;
                low_start = cyc;
                if (frames == 2) check("gap_clks", cyc - high_start, GAP_HIGH);
            end
            if (!SS_n && SCLK && !prev_sclk) begin
                if (rise_cnt > 0 && cyc - last_rise != SCLK_PER) per_bad++;
                rise_cnt++;
                last_rise = cyc;
                mosi_word = {mosi_word[14:0], MOSI};
            end
            if (SS_n && (SCLK !== 1'b1 || MOSI !== 1'b0)) idle_bad++;
            if (!prev_ss_n && SS_n) begin
                high_start = cyc;
                check("ss_low_clks", cyc - low_start, FRAME_LOW);
                check("sclk_rises", rise_cnt, 16);
                check("sclk_period_errs", per_bad, 0);
                if (sb.size() > 0) check("mosi_word", mosi_word, {2'b00, sb[0].ch, 11'h000});
            end
            if (cnv_cmplt && !prev_cmplt) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_cmplt: got cnv_cmplt=1 res=%03h, expected no completion", A2D_res);
                end else begin
                    e = sb.pop_front();
                    check("a2d_res", A2D_res, e.val);
                    check("latency", cyc - e.t0, LAT);
                    check("frames", frames, 2);
                    check("idle_sclk_mosi", idle_bad, 0);
                    $display("conv ch=%0d res=%03h exp=%03h latency=%0d frames=%0d",
                             e.ch, A2D_res, e.val, cyc - e.t0, frames);
                end
                frames   = 0;
                idle_bad = 0;
            end
        end
        prev_ss_n  = SS_n;
        prev_sclk  = SCLK;
        prev_cmplt = cnv_cmplt;
    end

    logic        have_result = 1'b0;
    logic [11:0] last_val    = 12'h000;

    task automatic run_conv(input logic [2:0] ch, input logic [11:0] val, input logic [3:0] nib,
                            input bit dup, input bit do_rst);
        exp_t e;
        int   d0;
        adc_mem[ch] = val;
        upper_nib   = nib;
        @(negedge clk);
        check("cmplt_level", cnv_cmplt, have_result);
        check("res_held", A2D_res, last_val);
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        check("cmplt_cleared", cnv_cmplt, 0);
        e.ch  = ch;
        e.val = val;
        e.t0  = cyc;
        sb.push_back(e);
        d0 = done_cnt;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
        if (dup) begin
            repeat (298) @(negedge clk);
            strt_cnv   = 1'b1;
            chnnl      = 3'd5;
            adc_mem[5] = 12'($urandom);
            @(negedge clk);
            strt_cnv = 1'b0;
        end
        if (do_rst) begin
            repeat (198) @(negedge clk);
            rst = 1'b1;
            sb.delete();
            @(negedge clk);
            rst = 1'b0;
            check("rst_ss_n", SS_n, 1);
            check("rst_sclk", SCLK, 1);
            check("rst_mosi", MOSI, 0);
            check("rst_cmplt", cnv_cmplt, 0);
            check("rst_res", A2D_res, 0);
            have_result = 1'b0;
            last_val    = 12'h000;
            return;
        end
        for (int i = 0; i < LAT + 50; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no cnv_cmplt for ch=%0d, expected one within %0d clks", ch, LAT + 50);
            sb.delete();
        end
        have_result = 1'b1;
        last_val    = val;
    endtask

    logic [2:0]  seq_ch  [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [11:0] seq_val [6] = '{12'h001, 12'hFFF, 12'h800, 12'h7FF, 12'h000, 12'h123};

    initial begin
        rst      = 1'b1;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        for (int i = 0; i < 8; i++) adc_mem[i] = 12'($urandom);
        repeat (3) @(negedge clk);
        check("init_ss_n", SS_n, 1);
        check("init_sclk", SCLK, 1);
        check("init_mosi", MOSI, 0);
        check("init_cmplt", cnv_cmplt, 0);
        check("init_res", A2D_res, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_conv(3'd6, 12'($urandom), 4'h0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        run_conv(3'd3, 12'hA5C, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_conv(seq_ch[i], seq_val[i], 4'h0, 1'b0, 1'b0);
        run_conv(3'd2, 12'($urandom), 4'h0, 1'b1, 1'b0);
        run_conv(3'd4, 12'h0A0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_conv(3'($urandom), 12'($urandom), 4'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
